// File: rtl/pwm_multi_channel.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_multi_channel
//  Purpose  : CH-channel PWM generator sharing one period counter; duty,
//             period and edge/center alignment are double-buffered and only
//             take effect at a period boundary.
//  Revision : 1.0
// ============================================================================
module pwm_multi_channel #(
    parameter int CH = 4,
    parameter int CW = 8,
    parameter int AW = $clog2(CH + 2)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [CW-1:0] wr_data,
    output logic [CH-1:0] pwm_out,
    output logic          period_tick
);

    localparam logic [AW-1:0] c_addr_period = AW'(CH);
    localparam logic [AW-1:0] c_addr_mode   = AW'(CH + 1);

    logic [CH-1:0][CW-1:0] duty_sh_q,  duty_sh_d;
    logic [CH-1:0][CW-1:0] duty_act_q, duty_act_d;
    logic [CW-1:0]         period_sh_q,  period_sh_d;
    logic [CW-1:0]         period_act_q, period_act_d;
    logic                  mode_sh_q,  mode_sh_d;
    logic                  mode_act_q, mode_act_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  dir_q, dir_d;
    logic [CH-1:0]         pwm_q, pwm_d;
    logic                  tick_q, tick_d;
    logic                  boundary;
    logic                  load_act;

    // Center mode with P == 1 never turns down: 0,1 is already a full period.
    always_comb begin
        boundary = 1'b0;
        if (period_act_q == '0) begin
            boundary = 1'b1;
        end else if (!mode_act_q) begin
            boundary = (cnt_q == period_act_q);
        end else begin
            boundary = (cnt_q == CW'(1)) && (dir_q || (period_act_q == CW'(1)));
        end
    end

    assign load_act = !en || boundary;

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (load_act) begin
            cnt_d = '0;
            dir_d = 1'b0;
        end else if (!mode_act_q) begin
            cnt_d = cnt_q + CW'(1);
        end else if (dir_q) begin
            cnt_d = cnt_q - CW'(1);
        end else if (cnt_q == period_act_q) begin
            dir_d = 1'b1;
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        period_sh_d  = (wr_en && (wr_addr == c_addr_period)) ? wr_data : period_sh_q;
        mode_sh_d    = (wr_en && (wr_addr == c_addr_mode)) ? wr_data[0] : mode_sh_q;
        period_act_d = load_act ? period_sh_q : period_act_q;
        mode_act_d   = load_act ? mode_sh_q : mode_act_q;
        tick_d       = en && boundary;
    end

    // Active copies take the pre-write shadow, so a boundary write lands a period later.
    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            assign duty_sh_d[i]  = (wr_en && (wr_addr == AW'(i))) ? wr_data : duty_sh_q[i];
            assign duty_act_d[i] = load_act ? duty_sh_q[i] : duty_act_q[i];
            assign pwm_d[i]      = en && (cnt_q < duty_act_q[i]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_sh_q    <= '0;
            duty_act_q   <= '0;
            period_sh_q  <= '1;
            period_act_q <= '1;
            mode_sh_q    <= 1'b0;
            mode_act_q   <= 1'b0;
            cnt_q        <= '0;
            dir_q        <= 1'b0;
            pwm_q        <= '0;
            tick_q       <= 1'b0;
        end else begin
            duty_sh_q    <= duty_sh_d;
            duty_act_q   <= duty_act_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            mode_sh_q    <= mode_sh_d;
            mode_act_q   <= mode_act_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            pwm_q        <= pwm_d;
            tick_q       <= tick_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_channel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_multi_channel
//  Purpose  : Self-checking bench for pwm_multi_channel (CH=4, CW=8).
//  Revision : 1.0
// ============================================================================
module tb_pwm_multi_channel;

    localparam int CH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [3:0] pwm_out;
    logic       period_tick;

    int total = 0;
    int bad = 0;

    pwm_multi_channel #(.CH(CH), .CW(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    // Reference model: position within the period, with the counter value derived from it.
    int unsigned m_duty_sh[CH];
    int unsigned m_duty_act[CH];
    int unsigned m_per_sh, m_per_act, m_ph;
    bit          m_mode_sh, m_mode_act;
    bit [3:0]    m_pwm;
    bit          m_tick;

    function automatic void chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endfunction

    function automatic int unsigned m_len();
        if (m_per_act == 0) return 1;
        return m_mode_act ? 2 * m_per_act : m_per_act + 1;
    endfunction

    function automatic int unsigned m_cnt();
        if (!m_mode_act || m_ph <= m_per_act) return m_ph;
        return 2 * m_per_act - m_ph;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            m_duty_sh[i]  = 0;
            m_duty_act[i] = 0;
        end
        m_per_sh = 255; m_per_act = 255; m_ph = 0;
        m_mode_sh = 0; m_mode_act = 0; m_pwm = '0; m_tick = 0;
    endfunction

    function automatic void model_edge();
        bit          bnd;
        int unsigned c;
        bnd = (m_ph == m_len() - 1);
        c   = m_cnt();
        for (int i = 0; i < CH; i++) m_pwm[i] = en && (c < m_duty_act[i]);
        m_tick = en && bnd;
        if (!en || bnd) begin
            for (int i = 0; i < CH; i++) m_duty_act[i] = m_duty_sh[i];
            m_per_act  = m_per_sh;
            m_mode_act = m_mode_sh;
            m_ph       = 0;
        end else begin
            m_ph++;
        end
        if (wr_en) begin
            if (int'(wr_addr) < CH) m_duty_sh[wr_addr] = wr_data;
            else if (int'(wr_addr) == CH) m_per_sh = wr_data;
            else if (int'(wr_addr) == CH + 1) m_mode_sh = wr_data[0];
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("pwm_vs_model", int'(pwm_out), int'(m_pwm));
        chk("tick_vs_model", int'(period_tick), int'(m_tick));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        model_reset();
        #1;
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_tick", int'(period_tick), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = 8'(d);
        step();
        wr_en = 1'b0;
    endtask

    // One window from a tick up to the next tick; optionally writes before the edge after sample wr_off.
    task automatic measure(input int ch, input int wr_off, input int a, input int d,
                           output int n, output int hi);
        int guard = 0;
        n = 0; hi = 0;
        while (!period_tick && guard < 600) begin
            step();
            guard++;
        end
        if (!period_tick) begin
            chk("tick_timeout", 0, 1);
            return;
        end
        n  = 1;
        hi = int'(pwm_out[ch]);
        while (n < 600) begin
            if (n == wr_off) begin
                wr_en = 1'b1; wr_addr = 3'(a); wr_data = 8'(d);
            end
            step();
            wr_en = 1'b0;
            if (period_tick) break;
            hi += int'(pwm_out[ch]);
            n++;
        end
        if (n >= 600) chk("window_timeout", 0, 1);
    endtask

    typedef struct {
        int mode;
        int per;
        int duty;
        int exp_len;
        int exp_hi;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n, hi;

        vecs[0] = '{0, 9, 3, 10, 3};
        vecs[1] = '{0, 9, 7, 10, 7};
        vecs[2] = '{1, 8, 3, 16, 5};
        vecs[3] = '{0, 9, 0, 10, 0};
        vecs[4] = '{0, 9, 255, 10, 10};
        vecs[5] = '{1, 8, 9, 16, 16};
        vecs[6] = '{1, 1, 1, 2, 1};
        vecs[7] = '{0, 0, 1, 1, 1};
        vecs[8] = '{1, 0, 0, 1, 0};
        vecs[9] = '{1, 5, 5, 10, 9};

        #2;
        do_reset();

        foreach (vecs[k]) begin
            do_reset();
            wr(0, vecs[k].duty);
            wr(CH, vecs[k].per);
            wr(CH + 1, vecs[k].mode);
            step();
            en = 1'b1;
            measure(0, -1, 0, 0, n, hi);
            chk($sformatf("vec%0d_len", k), n, vecs[k].exp_len);
            chk($sformatf("vec%0d_high", k), hi, vecs[k].exp_hi);
        end

        // Mid-period duty write: current pulse unaffected, next period uses new duty.
        do_reset();
        wr(0, 3); wr(CH, 9); step(); en = 1'b1;
        measure(0, -1, 0, 0, n, hi);
        measure(0, 3, 0, 7, n, hi);
        chk("midwr_cur_high", hi, 3);
        measure(0, -1, 0, 0, n, hi);
        chk("midwr_next_high", hi, 7);
        chk("midwr_next_len", n, 10);

        // Invalid address write changes nothing; boundary-edge write lands one period late.
        measure(0, 2, CH + 2, 0, n, hi);
        measure(0, -1, 0, 0, n, hi);
        chk("badaddr_high", hi, 7);
        wr(0, 3);
        measure(0, -1, 0, 0, n, hi);
        measure(0, 10, 0, 2, n, hi);
        chk("bndwr_w1_high", hi, 3);
        measure(0, -1, 0, 0, n, hi);
        chk("bndwr_w2_high", hi, 3);
        measure(0, -1, 0, 0, n, hi);
        chk("bndwr_w3_high", hi, 2);

        // Stuck-low and stuck-high channels across three periods.
        do_reset();
        wr(2, 0); wr(3, 255); wr(CH, 9); step(); en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            chk("duty0_stuck_low", int'(pwm_out[2]), 0);
            chk("dutymax_stuck_high", int'(pwm_out[3]), 1);
        end

        // Asynchronous reset with an output high, checked before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pwm", int'(pwm_out), 0);
        chk("async_rst_tick", int'(period_tick), 0);
        model_reset();
        en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wr(1, 200);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("en0_pwm", int'(pwm_out), 0);
            chk("en0_tick", int'(period_tick), 0);
        end

        // Randomised traffic against the reference model.
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 99) < 3) en = ~en;
            wr_en   = ($urandom_range(0, 99) < 15);
            wr_addr = 3'($urandom_range(0, 7));
            if (int'(wr_addr) == CH)
                wr_data = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            else if (int'(wr_addr) < CH)
                wr_data = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 14));
            else
                wr_data = 8'($urandom);
            step();
        end
        wr_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
